// File: rtl/addkey_bank_if.sv
// Bundle of the key-store write port, operation request and result signals of addkey_bank.
// The master drives keys and requests; the slave (the bank) returns finish/addkey/err.
interface addkey_bank_if #(
  parameter int WIDTH = 128,
  parameter int IDXW  = 4
);
  logic             key_wr;
  logic [IDXW-1:0]  key_wr_idx;
  logic [WIDTH-1:0] key_in;
  logic             start;
  logic [WIDTH-1:0] in;
  logic [IDXW-1:0]  key_idx;
  logic             chain;
  logic             chain_clr;
  logic             finish;
  logic [WIDTH-1:0] addkey;
  logic             err;

  modport master (
    output key_wr, key_wr_idx, key_in, start, in, key_idx, chain, chain_clr,
    input  finish, addkey, err
  );

  modport slave (
    input  key_wr, key_wr_idx, key_in, start, in, key_idx, chain, chain_clr,
    output finish, addkey, err
  );
endinterface

// File: rtl/addkey_bank.sv
// Round-key bank with AddRoundKey (XOR) datapath and optional chaining of the previous result.
// Operands are captured on request; the result is registered one edge later and held until start drops.
module addkey_bank #(
  parameter int WIDTH = 128,
  parameter int NKEYS = 11,
  parameter int IDXW  = 4
) (
  input  logic         clk,
  input  logic         rst,
  addkey_bank_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] key_store_q [NKEYS];
  logic [WIDTH-1:0] key_store_d [NKEYS];
  logic [WIDTH-1:0] in_q, in_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             chain_mode_q, chain_mode_d;
  logic             idx_err_q, idx_err_d;
  logic [WIDTH-1:0] chain_reg_q, chain_reg_d;
  logic [WIDTH-1:0] addkey_q, addkey_d;
  logic             finish_q, finish_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] sel_key;
  logic             sel_hit;
  logic [WIDTH-1:0] result;

  // Out-of-range indices find no entry, so the key term falls back to zero.
  always_comb begin
    sel_key = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (bus.key_idx == IDXW'(i)) begin
        sel_key = key_store_q[i];
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    key_store_d = key_store_q;
    for (int i = 0; i < NKEYS; i++) begin
      if (bus.key_wr && (bus.key_wr_idx == IDXW'(i))) begin
        key_store_d[i] = bus.key_in;
      end
    end
  end

  assign result = in_q ^ key_q ^ (chain_mode_q ? chain_reg_q : '0);

  always_comb begin
    state_d      = state_q;
    in_d         = in_q;
    key_d        = key_q;
    chain_mode_d = chain_mode_q;
    idx_err_d    = idx_err_q;
    chain_reg_d  = chain_reg_q;
    addkey_d     = addkey_q;
    finish_d     = finish_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        finish_d = 1'b0;
        if (bus.start) begin
          in_d         = bus.in;
          key_d        = sel_key;
          chain_mode_d = bus.chain;
          idx_err_d    = ~sel_hit;
          state_d      = CALC;
        end
      end
      CALC: begin
        if (bus.start) begin
          addkey_d    = result;
          err_d       = idx_err_q;
          chain_reg_d = result;
          finish_d    = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (!bus.start) begin
          finish_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A clear on the same edge as a result load takes priority.
    if (bus.chain_clr) begin
      chain_reg_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      in_q         <= '0;
      key_q        <= '0;
      chain_mode_q <= 1'b0;
      idx_err_q    <= 1'b0;
      chain_reg_q  <= '0;
      addkey_q     <= '0;
      finish_q     <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < NKEYS; i++) begin
        key_store_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      in_q         <= in_d;
      key_q        <= key_d;
      chain_mode_q <= chain_mode_d;
      idx_err_q    <= idx_err_d;
      chain_reg_q  <= chain_reg_d;
      addkey_q     <= addkey_d;
      finish_q     <= finish_d;
      err_q        <= err_d;
      key_store_q  <= key_store_d;
    end
  end

  assign bus.finish = finish_q;
  assign bus.addkey = addkey_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_addkey_bank.sv
// Directed and randomized checks of addkey_bank against a simple array/XOR model of the key bank.
module tb_addkey_bank;
  localparam int W  = 128;
  localparam int NK = 11;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0] modelKeys [NK];
  logic [W-1:0] modelChain;
  logic [W-1:0] modelAddkey;
  logic         modelErr;

  always #5 clk = ~clk;

  addkey_bank_if #(.WIDTH(W), .IDXW(IW)) bus ();

  addkey_bank #(.WIDTH(W), .NKEYS(NK), .IDXW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void modelWrite(input int idx, input logic [W-1:0] val);
    if (idx < NK) modelKeys[idx] = val;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NK; i++) modelKeys[i] = '0;
    modelChain  = '0;
    modelAddkey = '0;
    modelErr    = 1'b0;
  endfunction

  task automatic driveWrite(input logic en, input logic [IW-1:0] idx, input logic [W-1:0] val);
    bus.key_wr     = en;
    bus.key_wr_idx = idx;
    bus.key_in     = val;
  endtask

  task automatic writeKey(input int idx, input logic [W-1:0] val);
    driveWrite(1'b1, IW'(idx), val);
    tick();
    driveWrite(1'b0, '0, '0);
    modelWrite(idx, val);
  endtask

  // One full operation from IDLE: capture, result, optional hold, release.
  // wrPhase selects the edge of an optional key write: 0 capture, 1 result, 2 first hold cycle.
  task automatic applyStimulus(input logic [W-1:0] dIn, input int idx, input logic ch, input int hold,
                               input logic wrEn, input int wrIdx, input logic [W-1:0] wrVal,
                               input int wrPhase, input logic clrAtCalc);
    logic [W-1:0] keyTerm;
    logic         expErr;
    keyTerm = (idx < NK) ? modelKeys[idx] : '0;
    expErr  = (idx >= NK);
    bus.start   = 1'b1;
    bus.in      = dIn;
    bus.key_idx = IW'(idx);
    bus.chain   = ch;
    if (wrEn && wrPhase == 0) driveWrite(1'b1, IW'(wrIdx), wrVal);
    tick();
    driveWrite(1'b0, '0, '0);
    if (wrEn && wrPhase == 0) modelWrite(wrIdx, wrVal);
    checkOutput("capture_finish", W'(bus.finish), W'(1'b0));
    bus.in      = rand128();
    bus.key_idx = IW'($urandom);
    bus.chain   = 1'($urandom);
    if (wrEn && wrPhase == 1) driveWrite(1'b1, IW'(wrIdx), wrVal);
    bus.chain_clr = clrAtCalc;
    tick();
    driveWrite(1'b0, '0, '0);
    bus.chain_clr = 1'b0;
    if (wrEn && wrPhase == 1) modelWrite(wrIdx, wrVal);
    modelAddkey = dIn ^ keyTerm ^ (ch ? modelChain : '0);
    modelErr    = expErr;
    modelChain  = clrAtCalc ? '0 : modelAddkey;
    checkOutput("result_finish", W'(bus.finish), W'(1'b1));
    checkOutput("result_addkey", bus.addkey, modelAddkey);
    checkOutput("result_err", W'(bus.err), W'(modelErr));
    for (int h = 0; h < hold; h++) begin
      if (wrEn && wrPhase == 2 && h == 0) driveWrite(1'b1, IW'(wrIdx), wrVal);
      tick();
      driveWrite(1'b0, '0, '0);
      if (wrEn && wrPhase == 2 && h == 0) modelWrite(wrIdx, wrVal);
      checkOutput("hold_finish", W'(bus.finish), W'(1'b1));
      checkOutput("hold_addkey", bus.addkey, modelAddkey);
    end
    bus.start = 1'b0;
    tick();
    checkOutput("release_finish", W'(bus.finish), W'(1'b0));
    checkOutput("release_addkey", bus.addkey, modelAddkey);
    checkOutput("release_err", W'(bus.err), W'(modelErr));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] keptAddkey;
    modelReset();

    // Reset with busy-looking inputs that must be ignored.
    rst = 1'b0;
    bus.start = 1'b1;
    bus.in = rand128();
    bus.key_idx = '0;
    bus.chain = 1'b1;
    bus.chain_clr = 1'b0;
    driveWrite(1'b1, '0, rand128());
    tick();
    tick();
    checkOutput("reset_finish", W'(bus.finish), W'(1'b0));
    checkOutput("reset_addkey", bus.addkey, '0);
    checkOutput("reset_err", W'(bus.err), W'(1'b0));

    // First edge with reset released is already a capture edge.
    rst = 1'b1;
    driveWrite(1'b0, '0, '0);
    bus.start = 1'b0;
    applyStimulus(rand128(), 0, 1'b1, 0, 1'b0, 0, '0, 0, 1'b0);

    // Known-answer vectors.
    writeKey(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    applyStimulus(128'h6bc1bee22e409f96e93d7e117393172a, 0, 1'b0, 1, 1'b0, 0, '0, 0, 1'b0);
    checkOutput("kat_plain", bus.addkey, 128'h40bfabf406ee4d3042ca6b997a5c5816);
    applyStimulus(128'hae2d8a571e03ac9c9eb76fac45af8e51, 0, 1'b1, 0, 1'b0, 0, '0, 0, 1'b0);
    checkOutput("kat_chain", bus.addkey, 128'hc5ec34b53043330a778a11bd363c997b);
    bus.chain_clr = 1'b1;
    tick();
    bus.chain_clr = 1'b0;
    modelChain = '0;
    applyStimulus(128'hae2d8a571e03ac9c9eb76fac45af8e51, 0, 1'b1, 0, 1'b0, 0, '0, 0, 1'b0);
    checkOutput("kat_chain_cleared", bus.addkey, 128'h85539f4136ad7e3a35407a244c60c16d);

    // Out-of-range key index, then a valid one.
    applyStimulus(128'h30c81c46a35ce411e5fbc1191a0a52ef, NK, 1'b0, 0, 1'b0, 0, '0, 0, 1'b0);
    checkOutput("oor_addkey", bus.addkey, 128'h30c81c46a35ce411e5fbc1191a0a52ef);
    checkOutput("oor_err", W'(bus.err), W'(1'b1));
    applyStimulus(rand128(), 0, 1'b0, 0, 1'b0, 0, '0, 0, 1'b0);
    checkOutput("valid_after_oor_err", W'(bus.err), W'(1'b0));

    // Abort in CALC: no result, no chain update.
    keptAddkey = bus.addkey;
    bus.start = 1'b1;
    bus.in = rand128();
    bus.key_idx = 4'd0;
    bus.chain = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checkOutput("abort_finish", W'(bus.finish), W'(1'b0));
    checkOutput("abort_addkey", bus.addkey, keptAddkey);
    tick();
    checkOutput("abort_finish_later", W'(bus.finish), W'(1'b0));

    // Long hold in DONE, then chained ops confirm a single chain update.
    applyStimulus(rand128(), 0, 1'b1, 10, 1'b0, 0, '0, 0, 1'b0);
    applyStimulus(rand128(), 0, 1'b1, 0, 1'b0, 0, '0, 0, 1'b0);

    // Clear on the result edge wins over the chain load.
    applyStimulus(rand128(), 0, 1'b1, 0, 1'b0, 0, '0, 0, 1'b1);
    applyStimulus(rand128(), 0, 1'b1, 0, 1'b0, 0, '0, 0, 1'b0);

    // Key write on the capture edge is not seen; the next op sees it.
    writeKey(3, rand128());
    applyStimulus(rand128(), 3, 1'b0, 0, 1'b1, 3, rand128(), 0, 1'b0);
    applyStimulus(rand128(), 3, 1'b0, 0, 1'b0, 0, '0, 0, 1'b0);

    // Ignored write beyond the store.
    writeKey(NK + 1, rand128());

    // Randomized operations with writes in every phase.
    for (int i = 0; i < NK; i++) writeKey(i, rand128());
    for (int n = 0; n < 30; n++) begin
      applyStimulus(rand128(), $urandom_range(0, 12), 1'($urandom), $urandom_range(0, 3),
                    1'($urandom), $urandom_range(0, 15), rand128(), $urandom_range(0, 2),
                    ($urandom_range(0, 4) == 0));
    end

    // Reset while holding a result in DONE.
    bus.start = 1'b1;
    bus.in = rand128();
    bus.key_idx = 4'd1;
    bus.chain = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_finish", W'(bus.finish), W'(1'b1));
    rst = 1'b0;
    tick();
    checkOutput("done_reset_finish", W'(bus.finish), W'(1'b0));
    checkOutput("done_reset_addkey", bus.addkey, '0);
    checkOutput("done_reset_err", W'(bus.err), W'(1'b0));
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    modelReset();
    for (int i = 0; i < NK; i++) begin
      applyStimulus('0, i, 1'b0, 0, 1'b0, 0, '0, 0, 1'b0);
      checkOutput($sformatf("store_cleared_%0d", i), bus.addkey, '0);
    end
    applyStimulus(rand128(), NK + 2, 1'b1, 0, 1'b0, 0, '0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/addkey_bank.md
ADDKEY_BANK -- requirements
Module: addkey_bank

Interface
REQ-001 Parameter WIDTH, default 128, data and key width in bits.
REQ-002 Parameter NKEYS, default 11, number of round-key store entries.
REQ-003 Parameter IDXW, default 4, width of key index ports; the SHALL hold 2^IDXW >= NKEYS.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 key_wr  input  1  key store write strobe.
REQ-007 key_wr_idx  input  IDXW  key store write address.
REQ-008 key_in  input  WIDTH  key store write data.
REQ-009 start  input  1  operation request, level, held high until finish seen.
REQ-010 in  input  WIDTH  data block.
REQ-011 key_idx  input  IDXW  round-key select for the operation.
REQ-012 chain  input  1  1 = chained mode, 0 = plain AddRoundKey.
REQ-013 chain_clr  input  1  clears chaining register.
REQ-014 finish  output  1  result valid.
REQ-015 addkey  output  WIDTH  registered result.
REQ-016 err  output  1  key_idx out of range for the current result.

Function
REQ-017 Key store: NKEYS x WIDTH registers; key_wr=1 with key_wr_idx<NKEYS writes key_in at the edge; key_wr_idx>=NKEYS write ignored.
REQ-018 FSM states IDLE, CALC, DONE.
REQ-019 IDLE: start=1 at an edge captures in, key_idx, chain, and key store[key_idx] into operand registers; go CALC.
REQ-020 Operand capture is read-before-write: key_wr to the same index on the capture edge is not seen by this operation.
REQ-021 CALC: start=1 -> register addkey = in ^ key (chain=0) or in ^ key ^ chain_reg (chain=1), set finish=1, go DONE; start=0 -> abort to IDLE, addkey/err/chain_reg unchanged.
REQ-022 Latency: finish rises after the second rising edge at which start is sampled high.
REQ-023 Captured key_idx>=NKEYS: key term is zero, err=1 with the result; otherwise err=0.
REQ-024 On the CALC->DONE edge chain_reg loads the new addkey value, in both modes.
REQ-025 DONE: finish and addkey held while start=1; start=0 -> finish=0, go IDLE; addkey and err retain value.
REQ-026 A new operation requires start low for at least one edge after finish; start held high never re-triggers.
REQ-027 Key writes during CALC/DONE do not alter the in-flight or held result.
REQ-028 chain_clr=1 zeroes chain_reg at the edge; on the same edge as a chain_reg load, clear wins.
REQ-029 All XOR purely bitwise over WIDTH bits; no carry, no truncation.

Reset
REQ-030 rst=0 at an edge: state IDLE, finish=0, addkey=0, err=0, chain_reg=0, all key store entries 0, operand registers 0.
REQ-031 Reset in any state, including mid-CALC or DONE, aborts the operation with no result update.
REQ-032 Inputs ignored while rst=0; first operation may start on the first edge with rst=1.

Verification
REQ-033 Write key 2b7e151628aed2a6abf7158809cf4f3c to idx 0; chain=0, in=6bc1bee22e409f96e93d7e117393172a -> finish after 2 edges, addkey=40bfabf406ee4d3042ca6b997a5c5816, err=0.
REQ-034 Continue chain=1, in=ae2d8a571e03ac9c9eb76fac45af8e51, idx 0 -> addkey=c5ec34b53043330a778a11bd363c997b; then chain_clr pulse, repeat -> 85539f4136ad7e3a35407a244c60c16d.
REQ-035 key_idx=NKEYS, in=30c81c46a35ce411e5fbc1191a0a52ef -> addkey equals in, err=1; next valid op -> err=0.
REQ-036 Drop start in CALC -> finish never rises, addkey keeps prior value; start held in DONE for 10 cycles -> finish stays 1, single chain_reg update.
REQ-037 key_wr to idx 3 on the capture edge with new value -> result uses old idx-3 key; next op uses new key.
REQ-038 Assert rst=0 during DONE -> next edge finish=0, addkey=0, key store read back as zero via a chain=0 op on in=0.
